// File: rtl/proc_rst_sequencer_pkg.sv
// Shared types and helpers for the reset release sequencer.
// State encoding, counter sizing and default wait lengths live here.
package proc_rst_seq_pkg;

    localparam int DEF_BUS_WAIT = 16;
    localparam int DEF_PER_WAIT = 16;
    localparam int DEF_MB_WAIT  = 16;

    // S_CORE is only reachable when the core-only reset request is built in.
    typedef enum logic [2:0] {
        S_BUS  = 3'd0,
        S_PER  = 3'd1,
        S_MB   = 3'd2,
        S_DONE = 3'd3,
        S_CORE = 3'd4
    } seq_state_e;

    // One extra bit above $clog2 so a wait that is an exact power of two still fits.
    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/proc_rst_sequencer_if.sv
// Reset fan-out bundle of the sequencer: the released reset groups plus the
// optional core-only reset request. master = sequencer, slave = reset consumers.
interface proc_rst_sequencer_if #(
    parameter int C_NUM_BUS_RST              = 1,
    parameter int C_NUM_PERP_RST             = 1,
    parameter int C_NUM_INTERCONNECT_ARESETN = 1,
    parameter int C_NUM_PERP_ARESETN         = 1
);
    logic                                  core_rst_req;
    logic                                  mb_reset;
    logic [0:C_NUM_BUS_RST-1]              bus_struct_reset;
    logic [0:C_NUM_PERP_RST-1]             peripheral_reset;
    logic [0:C_NUM_INTERCONNECT_ARESETN-1] interconnect_aresetn;
    logic [0:C_NUM_PERP_ARESETN-1]         peripheral_aresetn;
    logic                                  seq_done;

    modport master (
        input  core_rst_req,
        output mb_reset, bus_struct_reset, peripheral_reset,
               interconnect_aresetn, peripheral_aresetn, seq_done
    );

    modport slave (
        output core_rst_req,
        input  mb_reset, bus_struct_reset, peripheral_reset,
               interconnect_aresetn, peripheral_aresetn, seq_done
    );
endinterface

// File: rtl/proc_rst_sequencer_cnt.sv
// Loadable saturating down-counter used to time each release step.
// Asynchronous clear forces RST_VAL so the first wait starts counting at once.
module proc_rst_seq_cnt #(
    parameter int           W       = 5,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/proc_rst_sequencer.sv
// Reset release sequencer: bus/interconnect, then peripherals, then the core,
// each after a programmable number of slowest_sync_clk cycles.
// Optional feature macro: SEQ_CORE_RST_EN (core-only reset re-entry from S_DONE).
module proc_rst_sequencer
    import proc_rst_seq_pkg::*;
#(
    parameter int C_BUS_WAIT                 = DEF_BUS_WAIT,
    parameter int C_PER_WAIT                 = DEF_PER_WAIT,
    parameter int C_MB_WAIT                  = DEF_MB_WAIT,
    parameter int C_NUM_BUS_RST              = 1,
    parameter int C_NUM_PERP_RST             = 1,
    parameter int C_NUM_INTERCONNECT_ARESETN = 1,
    parameter int C_NUM_PERP_ARESETN         = 1
) (
    input  logic                  slowest_sync_clk,
    input  logic                  lpf_rst_n,
    proc_rst_sequencer_if.master  rst_if
);
    localparam int CW = cnt_width(max3(C_BUS_WAIT, C_PER_WAIT, C_MB_WAIT));

    localparam logic [CW-1:0] BUS_LD = CW'(C_BUS_WAIT - 1);
    localparam logic [CW-1:0] PER_LD = CW'(C_PER_WAIT - 1);
    localparam logic [CW-1:0] MB_LD  = CW'(C_MB_WAIT - 1);

    seq_state_e state_q, state_d;

    // One flop per group and polarity, fanned out to the vector widths below.
    logic bus_rst_q,  bus_rst_d;
    logic per_rst_q,  per_rst_d;
    logic mb_rst_q,   mb_rst_d;
    logic done_q,     done_d;
    logic ic_rstn_q;
    logic per_rstn_q;

    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [CW-1:0] cnt_ld_val;

    proc_rst_seq_cnt #(
        .W       (CW),
        .RST_VAL (BUS_LD)
    ) u_cnt (
        .clk_i      (slowest_sync_clk),
        .rst_ni     (lpf_rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State and output registers; async reset puts every group back into reset.
    always_ff @(posedge slowest_sync_clk or negedge lpf_rst_n) begin
        if (!lpf_rst_n) begin
            state_q    <= S_BUS;
            bus_rst_q  <= 1'b1;
            per_rst_q  <= 1'b1;
            mb_rst_q   <= 1'b1;
            done_q     <= 1'b0;
            ic_rstn_q  <= 1'b0;
            per_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_rst_q  <= bus_rst_d;
            per_rst_q  <= per_rst_d;
            mb_rst_q   <= mb_rst_d;
            done_q     <= done_d;
            ic_rstn_q  <= ~bus_rst_d;
            per_rstn_q <= ~per_rst_d;
        end
    end

    // Next state: advance and release one group whenever the wait counter hits zero.
    always_comb begin
        state_d    = state_q;
        bus_rst_d  = bus_rst_q;
        per_rst_d  = per_rst_q;
        mb_rst_d   = mb_rst_q;
        done_d     = done_q;
        cnt_load   = 1'b0;
        cnt_ld_val = PER_LD;
        cnt_dec    = 1'b1;
        case (state_q)
            S_BUS: begin
                if (cnt_zero) begin
                    state_d    = S_PER;
                    cnt_load   = 1'b1;
                    cnt_ld_val = PER_LD;
                    bus_rst_d  = 1'b0;
                end
            end
            S_PER: begin
                if (cnt_zero) begin
                    state_d    = S_MB;
                    cnt_load   = 1'b1;
                    cnt_ld_val = MB_LD;
                    per_rst_d  = 1'b0;
                end
            end
            S_MB: begin
                if (cnt_zero) begin
                    state_d  = S_DONE;
                    mb_rst_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
`ifdef SEQ_CORE_RST_EN
                if (rst_if.core_rst_req) begin
                    state_d    = S_CORE;
                    cnt_load   = 1'b1;
                    cnt_ld_val = MB_LD;
                    mb_rst_d   = 1'b1;
                    done_d     = 1'b0;
                end
`endif
            end
`ifdef SEQ_CORE_RST_EN
            S_CORE: begin
                if (cnt_zero) begin
                    state_d  = S_DONE;
                    mb_rst_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

`ifndef SEQ_CORE_RST_EN
    logic unused_core_rst_req;
    assign unused_core_rst_req = rst_if.core_rst_req;
`endif

    assign rst_if.mb_reset             = mb_rst_q;
    assign rst_if.seq_done             = done_q;
    assign rst_if.bus_struct_reset     = {C_NUM_BUS_RST{bus_rst_q}};
    assign rst_if.peripheral_reset     = {C_NUM_PERP_RST{per_rst_q}};
    assign rst_if.interconnect_aresetn = {C_NUM_INTERCONNECT_ARESETN{ic_rstn_q}};
    assign rst_if.peripheral_aresetn   = {C_NUM_PERP_ARESETN{per_rstn_q}};
endmodule

// File: tb/tb_proc_rst_sequencer.sv
// Bench for proc_rst_sequencer: three configurations (defaults, all waits 1,
// vector width 3 with waits 5/3/7) share clock, reset and core request and are
// compared every cycle against an edge-count model of the release schedule.
module tb_proc_rst_sequencer;

    logic clk = 1'b0;
    logic lpf_rst_n = 1'b0;
    logic req = 1'b0;

    always #5 clk = ~clk;

    proc_rst_sequencer_if if_def ();
    proc_rst_sequencer_if if_fast ();
    proc_rst_sequencer_if #(
        .C_NUM_BUS_RST(3), .C_NUM_PERP_RST(3),
        .C_NUM_INTERCONNECT_ARESETN(3), .C_NUM_PERP_ARESETN(3)
    ) if_v3 ();

    assign if_def.core_rst_req  = req;
    assign if_fast.core_rst_req = req;
    assign if_v3.core_rst_req   = req;

    proc_rst_sequencer u_def (
        .slowest_sync_clk (clk),
        .lpf_rst_n        (lpf_rst_n),
        .rst_if           (if_def.master)
    );

    proc_rst_sequencer #(
        .C_BUS_WAIT(1), .C_PER_WAIT(1), .C_MB_WAIT(1)
    ) u_fast (
        .slowest_sync_clk (clk),
        .lpf_rst_n        (lpf_rst_n),
        .rst_if           (if_fast.master)
    );

    proc_rst_sequencer #(
        .C_BUS_WAIT(5), .C_PER_WAIT(3), .C_MB_WAIT(7),
        .C_NUM_BUS_RST(3), .C_NUM_PERP_RST(3),
        .C_NUM_INTERCONNECT_ARESETN(3), .C_NUM_PERP_ARESETN(3)
    ) u_v3 (
        .slowest_sync_clk (clk),
        .lpf_rst_n        (lpf_rst_n),
        .rst_if           (if_v3.master)
    );

    // Reference model: m_n counts rising edges since lpf_rst_n went high;
    // ce_* is the edge at which an in-flight core-only reset ends (0 = none).
    int m_n = 0;
    int ce_def = 0, ce_fast = 0, ce_v3 = 0;
    int n_cmp = 0, n_bad = 0;

    localparam logic [25:0] RST_ALL = {6'b111000, 6'b111000, 14'b1_111_111_000_000_0};

    function automatic int core_next(input int ce, input int n, input int tot,
                                     input int m, input logic r);
`ifdef SEQ_CORE_RST_EN
        if (ce != 0 && n == ce) return 0;
        if (ce == 0 && (n - 1) >= tot && r) return n + m;
        return ce;
`else
        return 0;
`endif
    endfunction

    // {mb, bus, per, ic_n, per_n, done} from edge count and core-reset state.
    function automatic logic [5:0] exp_grp(input int n, input int ce,
                                           input int b, input int p, input int m);
        logic bus_on, per_on, mb_on;
        bus_on = n < b;
        per_on = n < (b + p);
        mb_on  = (n < (b + p + m)) || (ce != 0);
        return {mb_on, bus_on, per_on, !bus_on, !per_on, !mb_on};
    endfunction

    function automatic logic [13:0] exp_vec(input int n, input int ce,
                                            input int b, input int p, input int m);
        logic [5:0] g;
        g = exp_grp(n, ce, b, p, m);
        return {g[5], {3{g[4]}}, {3{g[3]}}, {3{g[2]}}, {3{g[1]}}, g[0]};
    endfunction

    always @(posedge clk or negedge lpf_rst_n) begin
        if (!lpf_rst_n) begin
            m_n     <= 0;
            ce_def  <= 0;
            ce_fast <= 0;
            ce_v3   <= 0;
        end else begin
            m_n     <= m_n + 1;
            ce_def  <= core_next(ce_def,  m_n + 1, 48, 16, req);
            ce_fast <= core_next(ce_fast, m_n + 1, 3,  1,  req);
            ce_v3   <= core_next(ce_v3,   m_n + 1, 15, 7,  req);
        end
    end

    logic [25:0] act_all, exp_all;

    assign act_all = {
        if_def.mb_reset, if_def.bus_struct_reset, if_def.peripheral_reset,
        if_def.interconnect_aresetn, if_def.peripheral_aresetn, if_def.seq_done,
        if_fast.mb_reset, if_fast.bus_struct_reset, if_fast.peripheral_reset,
        if_fast.interconnect_aresetn, if_fast.peripheral_aresetn, if_fast.seq_done,
        if_v3.mb_reset, if_v3.bus_struct_reset, if_v3.peripheral_reset,
        if_v3.interconnect_aresetn, if_v3.peripheral_aresetn, if_v3.seq_done};

    always_comb begin
        exp_all = {exp_grp(m_n, ce_def, 16, 16, 16),
                   exp_grp(m_n, ce_fast, 1, 1, 1),
                   exp_vec(m_n, ce_v3, 5, 3, 7)};
    end

    // Drive req, take one rising edge, return at the following falling edge.
    task automatic cyc(input logic r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        lpf_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom_range(0, 1)));
            n_cmp++;
            if (act_all !== RST_ALL) begin
                n_bad++;
                $display("FAIL reset cyc=%0d act=%h exp=%h", i, act_all, RST_ALL);
            end
        end
    endtask

    task automatic test_defaults();
        lpf_rst_n = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            cyc(1'b0);
            n_cmp++;
            if (act_all !== exp_all) begin
                n_bad++;
                $display("FAIL defaults edge=%0d act=%h exp=%h", m_n, act_all, exp_all);
            end
            if (i == 15 || i == 16 || i == 32 || i == 48) begin
                n_cmp++;
                if (if_def.bus_struct_reset !== 1'(i < 16) ||
                    if_def.peripheral_reset !== 1'(i < 32) ||
                    if_def.mb_reset !== 1'(i < 48) || if_def.seq_done !== 1'(i >= 48)) begin
                    n_bad++;
                    $display("FAIL default_edges edge=%0d act=%b%b%b%b", i,
                             if_def.bus_struct_reset, if_def.peripheral_reset,
                             if_def.mb_reset, if_def.seq_done);
                end
            end
            if (i <= 3) begin
                n_cmp++;
                if (act_all[19:14] !== ((i == 1) ? 6'b101100 : (i == 2) ? 6'b100110 : 6'b000111)) begin
                    n_bad++;
                    $display("FAIL fast_edges edge=%0d act=%b", i, act_all[19:14]);
                end
            end
        end
    endtask

    task automatic test_async_mid();
        lpf_rst_n = 1'b0;
        cyc(1'b0);
        lpf_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b0);
        #2 lpf_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_all !== RST_ALL || if_def.bus_struct_reset !== 1'b1 ||
            if_def.interconnect_aresetn !== 1'b0) begin
            n_bad++;
            $display("FAIL async_mid act=%h exp=%h", act_all, RST_ALL);
        end
        @(negedge clk);
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) cyc(1'b0);
        lpf_rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0);
            n_cmp++;
            if (act_all !== exp_all || if_def.bus_struct_reset !== 1'(i < 16)) begin
                n_bad++;
                $display("FAIL async_rerelease edge=%0d act=%h exp=%h", m_n, act_all, exp_all);
            end
        end
    endtask

    task automatic test_core_req();
        // continue to S_DONE on every instance, then a single pulse, then held high
        while (m_n < 50) cyc(1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(i == 0);
            n_cmp++;
            if (act_all !== exp_all) begin
                n_bad++;
                $display("FAIL core_pulse edge=%0d act=%h exp=%h", m_n, act_all, exp_all);
            end
        end
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1);
            n_cmp++;
            if (act_all !== exp_all) begin
                n_bad++;
                $display("FAIL core_held edge=%0d act=%h exp=%h", m_n, act_all, exp_all);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            lpf_rst_n = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                cyc(1'($urandom_range(0, 1)));
                n_cmp++;
                if (act_all !== RST_ALL) begin
                    n_bad++;
                    $display("FAIL rand_reset it=%0d act=%h exp=%h", it, act_all, RST_ALL);
                end
            end
            lpf_rst_n = 1'b1;
            for (int i = 0; i < int'($urandom_range(1, 90)); i++) begin
                cyc($urandom_range(0, 3) == 0);
                n_cmp++;
                if (act_all !== exp_all) begin
                    n_bad++;
                    $display("FAIL rand it=%0d edge=%0d act=%h exp=%h", it, m_n, act_all, exp_all);
                end
                n_cmp++;
                if (if_v3.bus_struct_reset !== ~if_v3.interconnect_aresetn ||
                    if_v3.peripheral_reset !== ~if_v3.peripheral_aresetn ||
                    if_v3.mb_reset === if_v3.seq_done) begin
                    n_bad++;
                    $display("FAIL rand_pairs it=%0d edge=%0d act=%h", it, m_n, act_all[13:0]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_defaults();
        test_async_mid();
        test_core_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
